// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcodes, flag bundle and illegal-op range for alu_pipe.
package alu_pipe_pkg;

  // Opcodes 0-7 keep the legacy 8-bit ALU encoding.
  localparam logic [3:0] OP_ZERO = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_ONES = 4'd7;
  // Extended opcodes.
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SAR  = 4'd10;
  localparam logic [3:0] OP_INC  = 4'd11;

  // Every opcode from here up to 15 is undefined.
  localparam logic [3:0] ILLEGAL_OP_MIN = 4'd12;

  typedef struct packed {
    logic zf;
    logic cf;
    logic nf;
    logic vf;
  } alu_flags_t;

  // True when the opcode falls in the undefined range.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op >= ILLEGAL_OP_MIN);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result handshake bundle between the sequencer,
// alu_pipe and the writeback stage.
interface alu_pipe_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             use_acc;
  logic             acc_we;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zf;
  logic             cf;
  logic             nf;
  logic             vf;
  logic             illegal;
  logic [WIDTH-1:0] acc;

  // Producer/consumer side (sequencer + writeback).
  modport master (
    output in_valid, op, a, b, use_acc, acc_we, out_ready,
    input  in_ready, out_valid, y, zf, cf, nf, vf, illegal, acc
  );

  // ALU side.
  modport slave (
    input  in_valid, op, a, b, use_acc, acc_we, out_ready,
    output in_ready, out_valid, y, zf, cf, nf, vf, illegal, acc
  );

endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: purely combinational opcode and flag evaluation.
// Build option: ALU_PIPE_SAT_EN makes SUB/ADD/INC saturate instead of wrap;
// cf/vf keep reporting the raw overflow condition either way.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH:0]   inc_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   shl_ext_s;
  logic [WIDTH:0]   shr_ext_s;
  logic [WIDTH:0]   sar_ext_s;
  logic [WIDTH-1:0] res_s;
  logic             cf_s;
  logic             vf_s;
  logic             ill_s;

  // Evaluate the selected op; shifts use a one-bit extension so the last
  // bit shifted out lands in the extra bit (and is 0 for a zero shift).
  always_comb begin
    sum_s     = {1'b0, a} + {1'b0, b};
    diff_s    = {1'b0, a} - {1'b0, b};
    inc_s     = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    sh_s      = b[SHW-1:0];
    shl_ext_s = {1'b0, a} << sh_s;
    shr_ext_s = {a, 1'b0} >> sh_s;
    sar_ext_s = $signed({a, 1'b0}) >>> sh_s;
    res_s     = {WIDTH{1'b0}};
    cf_s      = 1'b0;
    vf_s      = 1'b0;
    ill_s     = 1'b0;
    case (op)
      OP_ZERO: res_s = {WIDTH{1'b0}};
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_NOT:  res_s = ~a;
      OP_SUB: begin
        cf_s = diff_s[WIDTH];
        vf_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
`ifdef ALU_PIPE_SAT_EN
        if (diff_s[WIDTH]) begin
          res_s = {WIDTH{1'b0}};
        end else begin
          res_s = diff_s[WIDTH-1:0];
        end
`else
        res_s = diff_s[WIDTH-1:0];
`endif
      end
      OP_ADD: begin
        cf_s = sum_s[WIDTH];
        vf_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
`ifdef ALU_PIPE_SAT_EN
        if (sum_s[WIDTH]) begin
          res_s = {WIDTH{1'b1}};
        end else begin
          res_s = sum_s[WIDTH-1:0];
        end
`else
        res_s = sum_s[WIDTH-1:0];
`endif
      end
      OP_ONES: res_s = {WIDTH{1'b1}};
      OP_SHL: begin
        res_s = shl_ext_s[WIDTH-1:0];
        cf_s  = shl_ext_s[WIDTH];
      end
      OP_SHR: begin
        res_s = shr_ext_s[WIDTH:1];
        cf_s  = shr_ext_s[0];
      end
      OP_SAR: begin
        res_s = sar_ext_s[WIDTH:1];
        cf_s  = sar_ext_s[0];
      end
      OP_INC: begin
        cf_s = inc_s[WIDTH];
        vf_s = !a[MSB] && inc_s[MSB];
`ifdef ALU_PIPE_SAT_EN
        if (inc_s[WIDTH]) begin
          res_s = {WIDTH{1'b1}};
        end else begin
          res_s = inc_s[WIDTH-1:0];
        end
`else
        res_s = inc_s[WIDTH-1:0];
`endif
      end
      default: begin
        res_s = {WIDTH{1'b0}};
        ill_s = is_illegal_op(op);
      end
    endcase
  end

  // Drive result and flags; an undefined op reports all flags clear.
  always_comb begin
    y        = res_s;
    illegal  = ill_s;
    flags.zf = !ill_s && (res_s == {WIDTH{1'b0}});
    flags.cf = cf_s;
    flags.nf = res_s[MSB];
    flags.vf = vf_s;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: one-stage valid/ready ALU with result register, status flags and
// accumulator. Build option: ALU_PIPE_SAT_EN (saturating SUB/ADD/INC, in core).
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_pipe_if.slave bus
);

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH-1:0] core_y_s;
  alu_flags_t       core_flags_s;
  logic             core_illegal_s;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  alu_flags_t       flags_q, flags_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  // Handshake: no skid buffer, so a slot opens only when the result
  // register is empty or being drained this cycle. B' always sees the
  // pre-update accumulator.
  always_comb begin
    in_ready_s = !out_valid_q || bus.out_ready;
    accept_s   = bus.in_valid && in_ready_s;
    if (bus.use_acc) begin
      b_eff_s = acc_q;
    end else begin
      b_eff_s = bus.b;
    end
  end

  alu_pipe_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op      (bus.op),
    .a       (bus.a),
    .b       (b_eff_s),
    .y       (core_y_s),
    .flags   (core_flags_s),
    .illegal (core_illegal_s)
  );

  // Next state: load on accept, drop valid on a bare pop, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    acc_d       = acc_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      y_d         = core_y_s;
      flags_d     = core_flags_s;
      illegal_d   = core_illegal_s;
      if (bus.acc_we && !core_illegal_s) begin
        acc_d = core_y_s;
      end else begin
        acc_d = acc_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Result register and accumulator; reset discards any held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      flags_q     <= alu_flags_t'(4'b0000);
      illegal_q   <= 1'b0;
      acc_q       <= {WIDTH{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
      acc_q       <= acc_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zf        = flags_q.zf;
  assign bus.cf        = flags_q.cf;
  assign bus.nf        = flags_q.nf;
  assign bus.vf        = flags_q.vf;
  assign bus.illegal   = illegal_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven vectors through a scoreboard queue, plus
// hand-written backpressure, accumulator and reset sequences (WIDTH=8).
module tb_alu_pipe;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       acc_we;
    logic [7:0] y;
    logic [3:0] fl;   // {zf, cf, nf, vf}
    logic       ill;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [3:0] fl;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  vec_t tbl[$];

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic ua, input logic we, input logic [7:0] y,
                              input logic [3:0] fl, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.use_acc = ua; v.acc_we = we;
    v.y = y; v.fl = fl; v.ill = ill;
    return v;
  endfunction

  // Scoreboard: compare the front expectation whenever the consumer takes a result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual y=%0h expected no result", bus.y);
      end else begin
        e = exp_q.pop_front();
        chk("sb_y", {24'd0, bus.y}, {24'd0, e.y});
        chk("sb_flags", {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, {28'd0, e.fl});
        chk("sb_illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
      end
    end
  end

  // Called at posedge+1; drives one request, returns at posedge+1 after accept.
  task automatic send(input vec_t v);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.op = v.op; bus.a = v.a; bus.b = v.b;
    bus.use_acc = v.use_acc; bus.acc_we = v.acc_we;
    e.y = v.y; e.fl = v.fl; e.ill = v.ill;
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_y"}, {24'd0, bus.y}, 32'd0);
    chk({tag, "_flags"}, {28'd0, bus.zf, bus.cf, bus.nf, bus.vf}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
    chk({tag, "_acc"}, {24'd0, bus.acc}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 4'd0; bus.a = 8'h00; bus.b = 8'h00;
    bus.use_acc = 1'b0; bus.acc_we = 1'b0; bus.out_ready = 1'b1;

    // Vector table: {op, a, b, use_acc, acc_we, y, {zf,cf,nf,vf}, illegal}
    tbl.push_back(mk(4'd1,  8'hAA, 8'hF0, 1'b0, 1'b0, 8'hA0, 4'b0010, 1'b0));
    tbl.push_back(mk(4'd2,  8'hAA, 8'hF0, 1'b0, 1'b0, 8'hFA, 4'b0010, 1'b0));
    tbl.push_back(mk(4'd3,  8'hAA, 8'hF0, 1'b0, 1'b0, 8'h5A, 4'b0000, 1'b0));
    tbl.push_back(mk(4'd4,  8'hAA, 8'h00, 1'b0, 1'b0, 8'h55, 4'b0000, 1'b0));
`ifdef ALU_PIPE_SAT_EN
    tbl.push_back(mk(4'd5,  8'h05, 8'h07, 1'b0, 1'b0, 8'h00, 4'b1100, 1'b0));
`else
    tbl.push_back(mk(4'd5,  8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 4'b0110, 1'b0));
`endif
    tbl.push_back(mk(4'd6,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0011, 1'b0));
`ifdef ALU_PIPE_SAT_EN
    tbl.push_back(mk(4'd6,  8'hFF, 8'h01, 1'b0, 1'b0, 8'hFF, 4'b0110, 1'b0));
`else
    tbl.push_back(mk(4'd6,  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b1100, 1'b0));
`endif
    tbl.push_back(mk(4'd0,  8'h12, 8'h34, 1'b0, 1'b0, 8'h00, 4'b1000, 1'b0));
    tbl.push_back(mk(4'd7,  8'h12, 8'h34, 1'b0, 1'b0, 8'hFF, 4'b0010, 1'b0));
    tbl.push_back(mk(4'd8,  8'h81, 8'h01, 1'b0, 1'b0, 8'h02, 4'b0100, 1'b0));
    tbl.push_back(mk(4'd9,  8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 4'b0100, 1'b0));
    tbl.push_back(mk(4'd10, 8'h81, 8'h01, 1'b0, 1'b0, 8'hC0, 4'b0110, 1'b0));
    tbl.push_back(mk(4'd9,  8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 4'b0010, 1'b0));
    tbl.push_back(mk(4'd8,  8'h03, 8'h0F, 1'b0, 1'b0, 8'h80, 4'b0110, 1'b0));
`ifdef ALU_PIPE_SAT_EN
    tbl.push_back(mk(4'd11, 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 4'b0110, 1'b0));
`else
    tbl.push_back(mk(4'd11, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b1100, 1'b0));
`endif
    tbl.push_back(mk(4'd11, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h80, 4'b0011, 1'b0));
    tbl.push_back(mk(4'd5,  8'h07, 8'h07, 1'b0, 1'b0, 8'h00, 4'b1000, 1'b0));
    tbl.push_back(mk(4'd5,  8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 4'b0001, 1'b0));
    tbl.push_back(mk(4'd12, 8'h55, 8'hAA, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b1));

    // Reset state.
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // First-result latency, then the table streamed back to back.
    send(tbl[0]);
    @(negedge clk);
    chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("latency_y", {24'd0, bus.y}, 32'h0000_00A0);
    @(posedge clk);
    #1;
    for (int i = 1; i < tbl.size(); i++) begin
      send(tbl[i]);
    end
    drain();

    // Backpressure: held result, in_ready low, then pop+accept on one edge.
    bus.out_ready = 1'b0;
    send(tbl[0]);
    bus.in_valid = 1'b1;
    bus.op = tbl[1].op; bus.a = tbl[1].a; bus.b = tbl[1].b;
    bus.use_acc = 1'b0; bus.acc_we = 1'b0;
    exp_q.push_back('{y: tbl[1].y, fl: tbl[1].fl, ill: tbl[1].ill});
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_y_stable", {24'd0, bus.y}, 32'h0000_00A0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_replace_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_replace_y", {24'd0, bus.y}, 32'h0000_00FA);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pop_valid_low", {31'd0, bus.out_valid}, 32'd0);
    chk("pop_y_hold", {24'd0, bus.y}, 32'h0000_00FA);
    @(posedge clk);
    #1;

    // Accumulator chain from reset.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(mk(4'd6, 8'h03, 8'h00, 1'b1, 1'b1, 8'h03, 4'b0000, 1'b0));
    send(mk(4'd6, 8'h03, 8'h00, 1'b1, 1'b1, 8'h06, 4'b0000, 1'b0));
    send(mk(4'd6, 8'h03, 8'h00, 1'b1, 1'b1, 8'h09, 4'b0000, 1'b0));
    drain();
    chk("acc_after_chain", {24'd0, bus.acc}, 32'h0000_0009);
    send(mk(4'd13, 8'h21, 8'h00, 1'b0, 1'b1, 8'h00, 4'b0000, 1'b1));
    drain();
    chk("acc_after_illegal", {24'd0, bus.acc}, 32'h0000_0009);

    // Reset mid-stream with a held result.
    bus.out_ready = 1'b0;
    send(tbl[2]);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("no_replay", {31'd0, bus.out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
